cl_frame_gen: RTL and testbench



---
 rtl/cl_pkg.sv | 23 ++
 rtl/cl_frame_gen_if.sv | 16 +
 rtl/cl_pattern_gen.sv | 33 +++
 rtl/cl_frame_gen.sv | 200 ++++++++++++++++++++
 tb/tb_cl_frame_gen.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cl_pkg.sv
// Shared Camera Link definitions: tap geometry, pixel pattern codes, frame FSM states.
package cl_pkg;

  localparam int unsigned N_TAP = 10;
  localparam int unsigned TAP_W = 8;
  localparam int unsigned FC_W  = 16;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_ROW   = 2'd1,
    PAT_FRAME = 2'd2,
    PAT_CONST = 2'd3
  } pat_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    LINE   = 3'd2,
    HBLANK = 3'd3,
    VBLANK = 3'd4
  } state_e;

endpackage

// File: rtl/cl_frame_gen_if.sv
// Camera Link video bus: frame valid, line valid and the multi-tap pixel word.
interface cl_frame_gen_if
  import cl_pkg::*;
#(
  parameter int unsigned N_TAP = cl_pkg::N_TAP,
  parameter int unsigned TAP_W = cl_pkg::TAP_W
);

  logic                     cl_fval;
  logic                     cl_lval;
  logic [N_TAP*TAP_W-1:0]   cl_data;

  modport master (output cl_fval, output cl_lval, output cl_data);
  modport slave  (input  cl_fval, input  cl_lval, input  cl_data);

endinterface

// File: rtl/cl_pattern_gen.sv
// Maps pattern select and raster position to the next pixel word; zero outside lval.
module cl_pattern_gen
  import cl_pkg::*;
#(
  parameter int unsigned N_TAP = cl_pkg::N_TAP,
  parameter int unsigned TAP_W = cl_pkg::TAP_W,
  parameter int unsigned COL_W = 8,
  parameter int unsigned ROW_W = 10
) (
  input  pat_e                   pattern,
  input  logic [COL_W-1:0]       col,
  input  logic [ROW_W-1:0]       row,
  input  logic [FC_W-1:0]        frame_count,
  input  logic                   lval,
  output logic [N_TAP*TAP_W-1:0] data_c
);

  // Per-tap pixel value for the selected pattern.
  always_comb begin
    data_c = '0;
    if (lval) begin
      for (int k = 0; k < int'(N_TAP); k++) begin
        case (pattern)
          PAT_RAMP:  data_c[k*TAP_W +: TAP_W] = TAP_W'(int'(col) * int'(N_TAP) + k);
          PAT_ROW:   data_c[k*TAP_W +: TAP_W] = TAP_W'(row);
          PAT_FRAME: data_c[k*TAP_W +: TAP_W] = TAP_W'(frame_count) ^ TAP_W'(col);
          default:   data_c[k*TAP_W +: TAP_W] = TAP_W'(8'hA5);
        endcase
      end
    end
  end

endmodule

// File: rtl/cl_frame_gen.sv
// Camera Link source emulator: frames of fixed geometry with a deterministic pixel pattern.
module cl_frame_gen
  import cl_pkg::*;
#(
  parameter int unsigned N_TAP     = cl_pkg::N_TAP,
  parameter int unsigned TAP_W     = cl_pkg::TAP_W,
  parameter int unsigned LINE_CLKS = 128,
  parameter int unsigned N_LINES   = 1024,
  parameter int unsigned FV_SETUP  = 2,
  parameter int unsigned H_BLANK   = 4,
  parameter int unsigned V_BLANK   = 16
) (
  input  logic                cl_clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic [FC_W-1:0]     n_frames,
  input  logic [1:0]          pattern,
  cl_frame_gen_if.master      cl,
  output logic                busy,
  output logic [FC_W-1:0]     frame_count,
  output logic                done
);

  localparam int unsigned DATA_W  = N_TAP * TAP_W;
  localparam int unsigned MAX_A   = (LINE_CLKS > FV_SETUP) ? LINE_CLKS : FV_SETUP;
  localparam int unsigned MAX_B   = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned ROW_W   = (N_LINES > 1) ? $clog2(N_LINES) : 1;

  // Input samples
  logic            start_q, stop_q;
  logic [FC_W-1:0] nf_q;
  logic [1:0]      pat_q;

  // Run state
  state_e             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ROW_W-1:0]   row, row_n;
  logic [FC_W-1:0]    nf_run, nf_n;
  pat_e               pat_run, pat_n;
  logic               stop_pend, stop_n;

  // Registered outputs
  logic               fval_q, fval_n;
  logic               lval_q, lval_n;
  logic [DATA_W-1:0]  data_q, data_n;
  logic               busy_n, done_n;
  logic [FC_W-1:0]    fc_n;

  assign cl.cl_fval = fval_q;
  assign cl.cl_lval = lval_q;
  assign cl.cl_data = data_q;

  // Register control inputs so no input reaches an output combinationally.
  always_ff @(posedge cl_clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      nf_q    <= '0;
      pat_q   <= '0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      nf_q    <= n_frames;
      pat_q   <= pattern;
    end
  end

  // Pixel word for the cycle being entered, driven by next-state raster position.
  cl_pattern_gen #(
    .N_TAP (N_TAP),
    .TAP_W (TAP_W),
    .COL_W (CNT_W),
    .ROW_W (ROW_W)
  ) u_pattern (
    .pattern     (pat_run),
    .col         (cnt_n),
    .row         (row_n),
    .frame_count (frame_count),
    .lval        (lval_n),
    .data_c      (data_n)
  );

  // State and output registers.
  always_ff @(posedge cl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      row         <= '0;
      nf_run      <= '0;
      pat_run     <= PAT_RAMP;
      stop_pend   <= 1'b0;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      data_q      <= '0;
      busy        <= 1'b0;
      frame_count <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      row         <= row_n;
      nf_run      <= nf_n;
      pat_run     <= pat_n;
      stop_pend   <= stop_n;
      fval_q      <= fval_n;
      lval_q      <= lval_n;
      data_q      <= data_n;
      busy        <= busy_n;
      frame_count <= fc_n;
      done        <= done_n;
    end
  end

  // Frame sequencing and next output values.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    row_n   = row;
    nf_n    = nf_run;
    pat_n   = pat_run;
    stop_n  = stop_pend | stop_q;
    fval_n  = fval_q;
    lval_n  = 1'b0;
    busy_n  = busy;
    fc_n    = frame_count;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        cnt_n  = '0;
        fval_n = 1'b0;
        busy_n = 1'b0;
        stop_n = 1'b0;
        if (start_q) begin
          state_n = SETUP;
          fval_n  = 1'b1;
          busy_n  = 1'b1;
          fc_n    = '0;
          nf_n    = nf_q;
          pat_n   = pat_e'(pat_q);
          stop_n  = stop_q;
        end
      end
      SETUP: begin
        fval_n = 1'b1;
        if (cnt == CNT_W'(FV_SETUP - 1)) begin
          state_n = LINE;
          cnt_n   = '0;
          row_n   = '0;
          lval_n  = 1'b1;
        end
      end
      LINE: begin
        lval_n = 1'b1;
        if (cnt == CNT_W'(LINE_CLKS - 1)) begin
          state_n = HBLANK;
          cnt_n   = '0;
          lval_n  = 1'b0;
        end
      end
      HBLANK: begin
        if (cnt == CNT_W'(H_BLANK - 1)) begin
          cnt_n = '0;
          if (row < ROW_W'(N_LINES - 1)) begin
            state_n = LINE;
            row_n   = row + ROW_W'(1);
            lval_n  = 1'b1;
          end else begin
            state_n = VBLANK;
            fval_n  = 1'b0;
            if (frame_count != {FC_W{1'b1}}) fc_n = frame_count + FC_W'(1);
          end
        end
      end
      VBLANK: begin
        fval_n = 1'b0;
        if (cnt == CNT_W'(V_BLANK - 1)) begin
          cnt_n = '0;
          if (stop_pend || stop_q || ((nf_run != '0) && (frame_count == nf_run))) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            stop_n  = 1'b0;
          end else begin
            state_n = SETUP;
            fval_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cl_frame_gen.sv
// Directed bench for cl_frame_gen on a small 23-clock frame geometry.
module tb_cl_frame_gen;
  import cl_pkg::*;

  localparam int unsigned LC = 4;
  localparam int unsigned NL = 3;
  localparam int unsigned FS = 2;
  localparam int unsigned HB = 2;
  localparam int unsigned VB = 3;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        start    = 1'b0;
  logic        stop     = 1'b0;
  logic [15:0] n_frames = '0;
  logic [1:0]  pattern  = '0;
  logic        busy;
  logic [15:0] frame_count;
  logic        done;

  cl_frame_gen_if #(.N_TAP(N_TAP), .TAP_W(TAP_W)) bus ();

  cl_frame_gen #(
    .N_TAP(N_TAP), .TAP_W(TAP_W), .LINE_CLKS(LC), .N_LINES(NL),
    .FV_SETUP(FS), .H_BLANK(HB), .V_BLANK(VB)
  ) dut (
    .cl_clk      (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .n_frames    (n_frames),
    .pattern     (pattern),
    .cl          (bus),
    .busy        (busy),
    .frame_count (frame_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc_no = 0, fv_hi = 0, lv_hi = 0, lv_bursts = 0, done_cnt = 0;
  int data_bad = 0, pix_bad = 0, gaps = 0, gap_bad = 0, gap_run = 0;
  int lcol = 0, brow = 0, frm = 0;
  int t_busy = 0, t_lv1 = -1, t_done = 0;
  logic [1:0] cur_pat = '0;
  logic p_fval = 1'b0, p_lval = 1'b0, p_busy = 1'b0;
  bit done_seen = 1'b0;
  logic busy_at_done = 1'b1;
  logic [7:0] cap_t3c2 = '0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_tap(input int k);
    case (cur_pat)
      2'd0:    return 8'(lcol * 10 + k);
      2'd1:    return 8'(brow);
      2'd2:    return 8'(frm) ^ 8'(lcol);
      default: return 8'hA5;
    endcase
  endfunction

  // One clock: sample at the falling edge and update the reference raster model.
  task automatic cyc();
    @(negedge clk);
    cyc_no++;
    if (busy && !p_busy) begin t_busy = cyc_no; t_lv1 = -1; end
    if (bus.cl_fval && !p_fval) brow = -1;
    if (!bus.cl_fval && p_fval) frm++;
    if (!busy) gap_run = 0;
    else if (!bus.cl_fval) gap_run++;
    if (bus.cl_fval && !p_fval) begin
      if (gap_run > 0) begin gaps++; if (gap_run != int'(VB)) gap_bad++; end
      gap_run = 0;
    end
    if (bus.cl_fval) fv_hi++;
    if (bus.cl_lval) begin
      if (!p_lval) begin
        lcol = 0; brow++; lv_bursts++;
        if (t_lv1 < 0) t_lv1 = cyc_no;
      end else lcol++;
      lv_hi++;
      for (int k = 0; k < 10; k++)
        if (bus.cl_data[k*8 +: 8] !== exp_tap(k)) pix_bad++;
      if (brow == 0 && lcol == 2) cap_t3c2 = bus.cl_data[31:24];
    end else if (bus.cl_data !== '0) data_bad++;
    if (done) begin done_cnt++; t_done = cyc_no; done_seen = 1'b1; busy_at_done = busy; end
    p_fval = bus.cl_fval; p_lval = bus.cl_lval; p_busy = busy;
  endtask

  task automatic start_run(input logic [15:0] nf, input logic [1:0] pat, input logic sp);
    n_frames = nf; pattern = pat; cur_pat = pat; frm = 0;
    start = 1'b1; stop = sp;
    cyc();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    done_seen = 1'b0;
    while (!done_seen && n < budget) begin cyc(); n++; end
    chk("done_seen", done_seen, 1'b1);
  endtask

  task automatic wait_line(input int f, input int c, input int budget);
    int n = 0;
    while (!(bus.cl_lval && frm == f && lcol == c) && n < budget) begin cyc(); n++; end
    chk("line_reached", (bus.cl_lval && frm == f && lcol == c), 1'b1);
  endtask

  initial begin
    int f0, l0, b0, d0, pb0, db0, g0, gb0;

    // Reset state
    repeat (3) cyc();
    chk("rst_fval", bus.cl_fval, 0);
    chk("rst_lval", bus.cl_lval, 0);
    chk("rst_data", bus.cl_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    repeat (2) cyc();

    // One frame, ramp pattern
    f0 = fv_hi; l0 = lv_hi; b0 = lv_bursts; d0 = done_cnt; pb0 = pix_bad;
    start_run(16'd1, PAT_RAMP, 1'b0);
    chk("t1_busy_pre", busy, 0);
    cyc();
    chk("t1_busy_rise", busy, 1);
    chk("t1_fval_rise", bus.cl_fval, 1);
    chk("t1_setup_data", bus.cl_data, 0);
    wait_done(60);
    chk("t1_fval_clks", fv_hi - f0, 20);
    chk("t1_lval_clks", lv_hi - l0, 12);
    chk("t1_bursts", lv_bursts - b0, 3);
    chk("t1_lval_lat", t_lv1 - t_busy, FS);
    chk("t1_period", t_done - t_busy, 23);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_busy_at_done", busy_at_done, 0);
    chk("t1_fc", frame_count, 1);
    chk("t1_tap3_col2", cap_t3c2, 8'd23);
    chk("t1_pix", pix_bad - pb0, 0);
    cyc();
    chk("t1_done_width", done, 0);

    // Three back-to-back frames, row pattern
    g0 = gaps; gb0 = gap_bad; b0 = lv_bursts; pb0 = pix_bad;
    start_run(16'd3, PAT_ROW, 1'b0);
    wait_done(150);
    chk("t2_period", t_done - t_busy, 69);
    chk("t2_gaps", gaps - g0, 2);
    chk("t2_gap_len", gap_bad - gb0, 0);
    chk("t2_bursts", lv_bursts - b0, 9);
    chk("t2_fc", frame_count, 3);
    chk("t2_pix", pix_bad - pb0, 0);

    // Free-running, stop mid-line of frame 2
    pb0 = pix_bad;
    start_run(16'd0, PAT_FRAME, 1'b0);
    wait_line(1, 1, 100);
    stop = 1'b1; cyc(); stop = 1'b0;
    wait_done(100);
    chk("t3_fc", frame_count, 2);
    chk("t3_frames", frm, 2);
    chk("t3_period", t_done - t_busy, 46);
    chk("t3_pix", pix_bad - pb0, 0);

    // start while busy is ignored
    pb0 = pix_bad; d0 = done_cnt;
    start_run(16'd1, PAT_RAMP, 1'b0);
    repeat (5) cyc();
    n_frames = 16'd5; pattern = PAT_CONST;
    start = 1'b1; cyc(); start = 1'b0;
    wait_done(60);
    chk("t4_period", t_done - t_busy, 23);
    chk("t4_fc", frame_count, 1);
    chk("t4_pix", pix_bad - pb0, 0);
    chk("t4_done_cnt", done_cnt - d0, 1);

    // start and stop together in idle: exactly one frame
    f0 = fv_hi;
    start_run(16'd3, PAT_RAMP, 1'b1);
    wait_done(100);
    chk("t4b_period", t_done - t_busy, 23);
    chk("t4b_fc", frame_count, 1);
    chk("t4b_fval_clks", fv_hi - f0, 20);

    // Reset mid-line
    start_run(16'd0, PAT_RAMP, 1'b0);
    wait_line(1, 1, 100);
    chk("t5_fc_pre", frame_count, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_fval", bus.cl_fval, 0);
    chk("t5_lval", bus.cl_lval, 0);
    chk("t5_data", bus.cl_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_fc", frame_count, 0);
    chk("t5_done", done, 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (8) cyc();
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_fval", bus.cl_fval, 0);
    f0 = fv_hi;
    start_run(16'd1, PAT_RAMP, 1'b0);
    wait_done(60);
    chk("t5_period", t_done - t_busy, 23);
    chk("t5_fval_clks", fv_hi - f0, 20);
    chk("t5_fc_after", frame_count, 1);

    // Constant pattern; data zero outside lval
    pb0 = pix_bad; db0 = data_bad;
    start_run(16'd1, PAT_CONST, 1'b0);
    cyc();
    chk("t6_setup_data", bus.cl_data, 0);
    wait_line(0, 0, 20);
    chk("t6_const", bus.cl_data, {10{8'hA5}});
    wait_done(60);
    chk("t6_pix", pix_bad - pb0, 0);
    chk("t6_blank_data", data_bad - db0, 0);
    chk("all_blank_data", data_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
